// File: rtl/expression_lane_pipe.sv
// expression_lane_pipe: LANES independent opcode-selected W-bit expression lanes
// evaluated combinationally, followed by an elastic DEPTH-stage valid/ready pipe
// with collapsing bubbles and an accepted-beat counter.

// One lane: opcode-selected expression on W-bit operands, signed or unsigned.
module expression_lane_op #(
    parameter int W = 6
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         sgn_i,
    input  logic [2:0]   op_i,
    output logic [W-1:0] y_o
);
    localparam int SW = $clog2(W);
    localparam logic [SW:0] WLIM = (SW+1)'(W);

    logic [SW-1:0]       s;
    logic                s_big;
    logic                lt;
    logic signed [W-1:0] sra;

    assign s     = b_i[SW-1:0];
    assign s_big = {1'b0, s} >= WLIM;
    assign lt    = sgn_i ? ($signed(a_i) < $signed(b_i)) : (a_i < b_i);
    // Kept in its own signed net so the surrounding mux cannot turn >>> logical.
    assign sra   = $signed(a_i) >>> s;

    // Opcode mux; out-of-range shifts saturate to 0 or to the sign fill.
    always_comb begin
        y_o = '0;
        case (op_i)
            3'd0: y_o = a_i + b_i;
            3'd1: y_o = a_i - b_i;
            3'd2: y_o = a_i & b_i;
            3'd3: y_o = a_i ^ b_i;
            3'd4: y_o = s_big ? '0 : (a_i << s);
            3'd5: begin
                if (sgn_i) y_o = s_big ? {W{a_i[W-1]}} : sra;
                else       y_o = s_big ? '0 : (a_i >> s);
            end
            3'd6:    y_o = {{(W-1){1'b0}}, lt};
            default: y_o = {{(W-1){1'b0}}, (a_i == b_i)};
        endcase
    end
endmodule

module expression_lane_pipe #(
    parameter int LANES = 6,
    parameter int W     = 6,
    parameter int DEPTH = 2,
    parameter int CNTW  = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [LANES*W-1:0] a,
    input  logic [LANES*W-1:0] b,
    input  logic [LANES-1:0]   sgn,
    input  logic [LANES*3-1:0] op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [LANES*W-1:0] y,
    output logic [CNTW-1:0]    beat_cnt
);
    logic [LANES-1:0][W-1:0]            eval;
    logic [DEPTH-1:0][LANES-1:0][W-1:0] data_q;
    logic [DEPTH-1:0]                   vld_q;
    logic [DEPTH-1:0]                   ld;
    logic [CNTW-1:0]                    cnt_q, cnt_d;
    logic                               accept;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        expression_lane_op #(.W(W)) u_lane (
            .a_i   (a[i*W +: W]),
            .b_i   (b[i*W +: W]),
            .sgn_i (sgn[i]),
            .op_i  (op[i*3 +: 3]),
            .y_o   (eval[i])
        );
    end

    // Stage i may load when empty or when its contents leave this cycle; the
    // chain runs from out_ready back to stage 0 so bubbles collapse.
    always_comb begin
        ld = '0;
        ld[DEPTH-1] = ~vld_q[DEPTH-1] | out_ready;
        for (int i = DEPTH-2; i >= 0; i--) ld[i] = ~vld_q[i] | ld[i+1];
    end

    assign in_ready  = ld[0];
    assign accept    = in_valid & in_ready;
    assign cnt_d     = accept ? cnt_q + CNTW'(1) : cnt_q;
    assign out_valid = vld_q[DEPTH-1];
    assign y         = data_q[DEPTH-1];
    assign beat_cnt  = cnt_q;

    // Pipe advance; data registers only capture a real beat, so y holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q  <= '0;
            data_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (ld[0])  vld_q[0]  <= in_valid;
            if (accept) data_q[0] <= eval;
            for (int i = 1; i < DEPTH; i++) begin
                if (ld[i])               vld_q[i]  <= vld_q[i-1];
                if (ld[i] && vld_q[i-1]) data_q[i] <= data_q[i-1];
            end
            cnt_q <= cnt_d;
        end
    end
endmodule

// File: tb/tb_expression_lane_pipe.sv
// Scoreboard bench for expression_lane_pipe: driver pushes expected beats on accept,
// a negedge monitor pops and compares on every handoff.
module tb_expression_lane_pipe;
    localparam int LANES = 6;
    localparam int W     = 6;
    localparam int DEPTH = 2;
    localparam int CNTW  = 16;
    localparam int N     = LANES * W;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic in_valid = 1'b0;
    logic out_ready = 1'b1;
    logic in_ready, out_valid, in_ready4, out_valid4;
    logic [N-1:0] a = '0, b = '0, y, y4;
    logic [LANES-1:0] sgn = '0;
    logic [LANES*3-1:0] op = '0;
    logic [CNTW-1:0] beat_cnt;
    logic [3:0] beat_cnt4;
    logic [N-1:0] exp_i = '0;

    int checks = 0, errors = 0, cnt = 0, hand_cnt = 0;
    logic [N-1:0] sb_q[$];
    bit rnd_mode = 1'b0;

    always #5 clk = ~clk;

    expression_lane_pipe #(.LANES(LANES), .W(W), .DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sgn(sgn), .op(op), .out_valid(out_valid),
        .out_ready(out_ready), .y(y), .beat_cnt(beat_cnt)
    );

    expression_lane_pipe #(.LANES(LANES), .W(W), .DEPTH(DEPTH), .CNTW(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
        .a(a), .b(b), .sgn(sgn), .op(op), .out_valid(out_valid4),
        .out_ready(out_ready), .y(y4), .beat_cnt(beat_cnt4)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] rep(input logic [W-1:0] v);
        return {LANES{v}};
    endfunction

    function automatic logic [LANES*3-1:0] repop(input logic [2:0] o);
        return {LANES{o}};
    endfunction

    // Integer reference for one lane.
    function automatic logic [W-1:0] ref_lane(input int av, input int bv, input bit sg, input int o);
        int m, sa, sb, s, r;
        m  = 1 << W;
        sa = (sg && av >= m/2) ? av - m : av;
        sb = (sg && bv >= m/2) ? bv - m : bv;
        s  = bv % (1 << $clog2(W));
        r  = 0;
        case (o)
            0: r = av + bv;
            1: r = av - bv;
            2: r = av & bv;
            3: r = av ^ bv;
            4: r = (s >= W) ? 0 : (av << s);
            5: if (sg) r = (s >= W) ? ((sa < 0) ? -1 : 0) : (sa >>> s);
               else    r = (s >= W) ? 0 : (av >> s);
            6: r = (sa < sb) ? 1 : 0;
            default: r = (av == bv) ? 1 : 0;
        endcase
        return r[W-1:0];
    endfunction

    function automatic logic [N-1:0] model(input logic [N-1:0] ta, input logic [N-1:0] tb,
                                           input logic [LANES-1:0] ts, input logic [LANES*3-1:0] to);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < LANES; i++)
            r[i*W +: W] = ref_lane(int'(ta[i*W +: W]), int'(tb[i*W +: W]), ts[i], int'(to[i*3 +: 3]));
        return r;
    endfunction

    // Monitor: count accepts, pop/compare on handoff, flush on reset.
    always @(negedge clk) begin
        if (reset) begin
            sb_q.delete();
            cnt = 0;
        end else begin
            chk("beat_cnt", beat_cnt, CNTW'(cnt));
            chk("beat_cnt4", beat_cnt4, cnt % 16);
            if (out_valid && out_ready) begin
                hand_cnt++;
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL spurious_out actual=%0h required=no beat t=%0t", y, $time);
                end else begin
                    chk("y", y, sb_q.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(exp_i);
                cnt++;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Present one beat and hold it until accepted; starts and ends at posedge+1.
    task automatic drive(input logic [N-1:0] ta, input logic [N-1:0] tb, input logic [LANES-1:0] ts,
                         input logic [LANES*3-1:0] to, input logic [N-1:0] te);
        int n;
        n = 0;
        a = ta; b = tb; sgn = ts; op = to; exp_i = te; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready) begin
            n++;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL accept_timeout actual=no accept required=accept t=%0t", $time);
                break;
            end
            @(posedge clk); #1;
            if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rnd_mode) out_ready = 1'($urandom_range(0, 1));
    endtask

    // Cycles from the accept cycle until out_valid, called right after drive().
    task automatic lat_check(input string nm);
        int lat;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 20) begin @(negedge clk); lat++; end
        chk(nm, lat, DEPTH);
        @(posedge clk); #1;
    endtask

    task automatic set_beat(input int k);
        a = rep(W'(k)); b = rep(W'(3*k)); sgn = '0; op = repop(3'd0); exp_i = rep(W'(4*k));
        in_valid = 1'b1;
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        logic [LANES-1:0] rs;
        logic [LANES*3-1:0] ro;
        int idx, h0;

        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // ADD unsigned with latency
        drive(rep(6'd60), rep(6'd10), '0, repop(3'd0), rep(6'd6));
        lat_check("add_latency");

        // SHR signed / unsigned / saturated
        drive(rep(6'b111000), rep(6'd1), '1, repop(3'd5), rep(6'b111100));
        drive(rep(6'b111000), rep(6'd1), '0, repop(3'd5), rep(6'b011100));
        drive(rep(6'b111000), rep(6'd7), '1, repop(3'd5), rep(6'b111111));
        // LT / EQ
        drive(rep(6'h3F), rep(6'd1), '1, repop(3'd6), rep(6'd1));
        drive(rep(6'h3F), rep(6'd1), '0, repop(3'd6), rep(6'd0));
        drive(rep(6'd5), rep(6'd5), 6'b101010, repop(3'd7), rep(6'd1));
        // Mixed lanes: SUB, AND, XOR, SHL, SHL s=W, SHR unsigned s=W
        drive({6'd63, 6'd1, 6'd3, 6'd42, 6'd42, 6'd3},
              {6'd6, 6'd6, 6'd4, 6'd15, 6'd15, 6'd5}, '0,
              {3'd5, 3'd4, 3'd4, 3'd3, 3'd2, 3'd1},
              {6'd0, 6'd0, 6'd48, 6'd37, 6'd10, 6'd62});
        cyc(DEPTH + 1);

        // Backpressure: capacity DEPTH, then drain at one beat per cycle
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 6; c++) begin
            if (idx < 5) set_beat(idx); else in_valid = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        chk("bp_accepted", idx, DEPTH);
        chk("bp_in_ready", in_ready, 0);
        out_ready = 1'b1;
        h0 = hand_cnt;
        for (int c = 0; c < 5; c++) begin
            if (idx < 5) set_beat(idx); else in_valid = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) idx++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("bp_drain", hand_cnt - h0, 5);
        chk("bp_all_in", idx, 5);
        cyc(2);

        // Reset with two beats in flight; a beat offered during reset is ignored
        out_ready = 1'b0;
        drive(rep(6'd1), rep(6'd2), '0, repop(3'd0), rep(6'd3));
        drive(rep(6'd4), rep(6'd2), '0, repop(3'd0), rep(6'd6));
        reset = 1'b1;
        set_beat(2);
        cyc(1);
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_beat_cnt", beat_cnt, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(rep(6'd9), rep(6'd9), '0, repop(3'd3), rep(6'd0));
        lat_check("post_rst_latency");
        cyc(2);

        // Counter wrap on the CNTW=4 instance
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        for (int k = 0; k < 17; k++) drive(rep(6'(k)), rep(6'd1), '0, repop(3'd2), rep(6'(k & 1)));
        @(negedge clk);
        chk("wrap4", beat_cnt4, 1);
        chk("cnt17", beat_cnt, 17);
        @(posedge clk); #1;
        cyc(DEPTH + 1);

        // Random ops against the reference model with random backpressure
        rnd_mode = 1'b1;
        for (int k = 0; k < 10000; k++) begin
            ra = N'({$urandom, $urandom});
            rb = N'({$urandom, $urandom});
            rs = LANES'($urandom);
            ro = (LANES*3)'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                cyc(1);
                out_ready = 1'($urandom_range(0, 1));
            end
            drive(ra, rb, rs, ro, model(ra, rb, rs, ro));
        end
        rnd_mode = 1'b0;
        out_ready = 1'b1;
        cyc(DEPTH + 3);
        chk("sb_empty", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end
endmodule
